// File: rtl/ascii_fixed_parser.sv
// ascii_fixed_parser: streams ASCII decimal text (one char per handshake, LF-terminated)
// into a signed INT_W.FRAC_W fixed-point value with zero and error flags.
module ascii_fixed_parser #(
  parameter int INT_W = 8,
  parameter int FRAC_W = 8,
  parameter int MAX_FRAC_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_char,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INT_W+FRAC_W-1:0] out_value,
  output logic                    out_zero,
  output logic                    out_err
);
  localparam int W = INT_W + FRAC_W;
  localparam int FW = $clog2(2 * 10 ** MAX_FRAC_DIGITS + 1);
  localparam int IW = INT_W + 4;
  localparam int NW = $clog2(MAX_FRAC_DIGITS + 1);
  localparam int CW = $clog2(FRAC_W + 1);
  localparam logic [2:0] SIGN = 3'd0, INT = 3'd1, FRAC = 3'd2, SKIP = 3'd3, CONV = 3'd4, OUT = 3'd5;
  logic [2:0] state_q, state_d;
  logic live_q, neg_q, neg_d, err_q, err_d, seen_q, seen_d;
  logic [INT_W-1:0] int_q, int_d;
  logic [FW-1:0] frac_q, frac_d, scale_q, scale_d, frac_sh;
  logic [FRAC_W-1:0] bits_q, bits_d;
  logic [NW-1:0] nf_q, nf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] val_q, val_d, mag;
  logic vld_q, vld_d, zero_q, zero_d, oerr_q, oerr_d;
  logic acc, is_dig, is_lf, ovf, bit_n;
  logic [IW-1:0] int_next;
  assign in_ready = live_q && !state_q[2];
  assign out_valid = vld_q;
  assign out_value = val_q;
  assign out_zero = zero_q;
  assign out_err = oerr_q;
  assign acc = in_valid && in_ready;
  assign is_dig = in_char >= "0" && in_char <= "9";
  assign is_lf = in_char == 8'h0A;
  assign int_next = IW'(int_q) * IW'(10) + IW'(in_char[3:0]);
  // magnitude must fit in INT_W-1 bits so the sign bit stays free
  assign ovf = |int_next[IW-1:INT_W-1];
  assign frac_sh = {frac_q[FW-2:0], 1'b0};
  assign bit_n = frac_sh >= scale_q;
  assign mag = {int_q, bits_q};
  always_comb begin
    state_d = state_q;
    neg_d = neg_q;
    err_d = err_q;
    seen_d = seen_q;
    int_d = int_q;
    frac_d = frac_q;
    scale_d = scale_q;
    bits_d = bits_q;
    nf_d = nf_q;
    cnt_d = cnt_q;
    val_d = val_q;
    vld_d = vld_q;
    zero_d = zero_q;
    oerr_d = oerr_q;
    case (state_q)
      SIGN, INT, FRAC: if (acc) begin
        if (is_lf) begin
          state_d = seen_q ? CONV : OUT;
          err_d = !seen_q;
          cnt_d = '0;
        end else if (is_dig && state_q == FRAC) begin
          seen_d = 1'b1;
          if (nf_q < NW'(MAX_FRAC_DIGITS)) begin
            frac_d = frac_q * FW'(10) + FW'(in_char[3:0]);
            scale_d = scale_q * FW'(10);
            nf_d = nf_q + 1'b1;
          end
        end else if (is_dig) begin
          seen_d = 1'b1;
          int_d = int_next[INT_W-1:0];
          state_d = ovf ? SKIP : INT;
          err_d = ovf;
        end else if (in_char == "." && state_q != FRAC) begin
          state_d = FRAC;
        end else if (state_q == SIGN && (in_char == "-" || in_char == "+")) begin
          neg_d = in_char == "-";
          state_d = INT;
        end else begin
          state_d = SKIP;
          err_d = 1'b1;
        end
      end
      SKIP: state_d = (acc && is_lf) ? OUT : SKIP;
      CONV: begin
        frac_d = bit_n ? frac_sh - scale_q : frac_sh;
        bits_d = {bits_q[FRAC_W-2:0], bit_n};
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(FRAC_W - 1)) ? OUT : CONV;
      end
      OUT: if (!vld_q) begin
        vld_d = 1'b1;
        oerr_d = err_q;
        val_d = err_q ? '0 : (neg_q ? -mag : mag);
        zero_d = !err_q && mag == '0;
      end else if (out_ready) begin
        vld_d = 1'b0;
        state_d = SIGN;
        neg_d = 1'b0;
        err_d = 1'b0;
        seen_d = 1'b0;
        int_d = '0;
        frac_d = '0;
        scale_d = FW'(1);
        bits_d = '0;
        nf_d = '0;
        cnt_d = '0;
      end
      default: state_d = SIGN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SIGN;
      live_q <= 1'b0;
      neg_q <= 1'b0;
      err_q <= 1'b0;
      seen_q <= 1'b0;
      int_q <= '0;
      frac_q <= '0;
      scale_q <= FW'(1);
      bits_q <= '0;
      nf_q <= '0;
      cnt_q <= '0;
      val_q <= '0;
      vld_q <= 1'b0;
      zero_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q <= 1'b1;
      neg_q <= neg_d;
      err_q <= err_d;
      seen_q <= seen_d;
      int_q <= int_d;
      frac_q <= frac_d;
      scale_q <= scale_d;
      bits_q <= bits_d;
      nf_q <= nf_d;
      cnt_q <= cnt_d;
      val_q <= val_d;
      vld_q <= vld_d;
      zero_q <= zero_d;
      oerr_q <= oerr_d;
    end
  end
endmodule

// File: tb/tb_ascii_fixed_parser.sv
// tb_ascii_fixed_parser: directed-vector bench for ascii_fixed_parser.
module tb_ascii_fixed_parser;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_char = 0;
  logic in_ready, out_valid, out_zero, out_err;
  logic [15:0] out_value;
  int edges = 0, k = 0, checks = 0, errors = 0;

  ascii_fixed_parser dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .out_zero(out_zero),
    .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic send(input logic [7:0] c);
    int n = 0;
    in_valid = 1;
    in_char = c;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready char=%h in_ready=%b required 1", c, in_ready);
    end
    @(posedge clk);
    #1 k = edges;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic run(input string s, output logic [15:0] v, output logic z, output logic e, output int lat);
    int n = 0;
    for (int i = 0; i < s.len(); i++) send(s[i]);
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    lat = out_valid ? edges - k : -1;
    v = out_value;
    z = out_zero;
    e = out_err;
  endtask

  task automatic ack;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_value, out_zero, out_err} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b val=%h z=%b e=%b required all 0", in_ready, out_valid, out_value, out_zero, out_err);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_numbers;
    string s[13] = '{"0\n", "0.0\n", "-0.000\n", "3.25\n", "-1.5\n", "+2\n", "0.1\n", "127.99999\n",
                     "128\n", "1a2\n", "1..2\n", "\n", ".\n"};
    logic [15:0] ev[13] = '{16'h0000, 16'h0000, 16'h0000, 16'h0340, 16'hFE80, 16'h0200, 16'h0019, 16'h7FFF,
                            16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    logic ez[13] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic ee[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [15:0] v;
    logic z, e;
    int lat;
    for (int i = 0; i < 13; i++) begin
      run(s[i], v, z, e, lat);
      checks += 4;
      if (v !== ev[i]) begin
        errors++;
        $display("FAIL num%0d_value got %h required %h", i, v, ev[i]);
      end
      if (z !== ez[i]) begin
        errors++;
        $display("FAIL num%0d_zero got %b required %b", i, z, ez[i]);
      end
      if (e !== ee[i]) begin
        errors++;
        $display("FAIL num%0d_err got %b required %b", i, e, ee[i]);
      end
      if (lat != (ee[i] ? 1 : 9)) begin
        errors++;
        $display("FAIL num%0d_latency got %0d required %0d", i, lat, ee[i] ? 1 : 9);
      end
      ack();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL num%0d_after_ack rdy=%b vld=%b required 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] v;
    logic z, e;
    int lat;
    run("12\n", v, z, e, lat);
    checks++;
    if (lat != 9) begin
      errors++;
      $display("FAIL bp_latency got %0d required 9", lat);
    end
    in_valid = 1;
    in_char = "9";
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_value !== 16'h0C00 || out_zero !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d vld=%b val=%h z=%b e=%b rdy=%b required 1 0c00 0 0 0", i, out_valid, out_value, out_zero, out_err, in_ready);
      end
    end
    ack();
    run("9\n", v, z, e, lat);
    checks++;
    if (v !== 16'h0900 || e !== 1'b0) begin
      errors++;
      $display("FAIL bp_held_char got %h err=%b required 0900 0", v, e);
    end
    ack();
  endtask

  task automatic test_midreset;
    logic [15:0] v;
    logic z, e;
    int lat;
    send("1");
    send("2");
    send(".");
    rst_n = 0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_value, out_zero, out_err} !== 20'h0) begin
      errors++;
      $display("FAIL midreset_outputs rdy=%b vld=%b val=%h z=%b e=%b required all 0", in_ready, out_valid, out_value, out_zero, out_err);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run("5\n", v, z, e, lat);
    checks++;
    if (v !== 16'h0500 || z !== 1'b0 || e !== 1'b0) begin
      errors++;
      $display("FAIL midreset_next got %h z=%b e=%b required 0500 0 0", v, z, e);
    end
    ack();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_numbers();
    test_backpressure();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ascii_fixed_parser.md
# ascii_fixed_parser

Streaming parser that turns ASCII decimal text into signed fixed-point numbers. Input is one character per handshake, for example "0", "0.0", "-3.25", each ended by a line feed. Output is a two's-complement value with an explicit zero flag, so downstream logic compares registered integers instead of simulator reals or strings. It sits between the text/UART character stream and the numeric datapath, as the reading end of the team's value-display path.

## Interface
- INT_W, 8: integer bits of the result, including sign.
- FRAC_W, 8: fraction bits of the result.
- MAX_FRAC_DIGITS, 4: decimal fraction digits kept; further digits are accepted and ignored (truncation).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  in_char is valid.
- in_ready  output  1  parser accepts a character this cycle.
- in_char  input  8  ASCII character.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_value  output  INT_W+FRAC_W  signed result in Q(INT_W-FRAC_W... i.e. INT_W.FRAC_W) two's complement.
- out_zero  output  1  result equals zero; 0 whenever out_err=1.
- out_err  output  1  malformed or out-of-range input; out_value=0 when set.

## Operation
- A character is accepted on an edge where in_valid and in_ready are both high.
- States:
  - SIGN: start of a number.
  - INT: integer digits.
  - FRAC: fraction digits.
  - SKIP: an error was seen; discard characters.
  - CONV: fraction-to-binary conversion.
  - OUT: result held for the consumer.
- in_ready is 1 in SIGN, INT, FRAC and SKIP; it is 0 in CONV and OUT.
- In SIGN:
  - '-' sets neg and goes to INT; '+' goes to INT.
  - A digit is accumulated and goes to INT.
  - '.' goes to FRAC.
  - 0x0A is an error: go to OUT with the error result.
  - Any other character sets err and goes to SKIP.
- In INT:
  - A digit updates int_acc = int_acc*10 + d.
  - If the new magnitude is 2^(INT_W-1) or more, set err and go to SKIP.
  - '.' goes to FRAC.
  - 0x0A goes to CONV.
- In FRAC:
  - The first MAX_FRAC_DIGITS digits update frac_acc = frac_acc*10 + d and scale = scale*10; scale starts at 1.
  - Later digits are accepted and dropped.
  - 0x0A goes to CONV.
  - A second '.' or any non-digit sets err and goes to SKIP.
- A number with no digit at all ("", "-", ".", "-.") is an error when its 0x0A arrives.
- In SKIP: all characters are discarded until 0x0A, which goes to OUT with out_err=1.
- CONV runs for FRAC_W cycles. Each cycle: frac_acc = frac_acc<<1; the next fraction bit (MSB first) = (frac_acc >= scale); subtract scale when that bit is 1. This is truncation toward zero of the magnitude.
- Result:
  - mag = {int_acc, frac_bits}; out_value = neg ? -mag : mag.
  - out_zero = (mag == 0). "-0" yields 0 with out_zero=1; there is no negative zero.
- In OUT: outputs hold until out_valid && out_ready. Then all accumulators, neg and err clear, and the state returns to SIGN.

## Timing
- Reset values:
  - in_ready=0 while rst_n=0, 1 from the first cycle after release.
  - out_valid=0, out_value=0, out_zero=0, out_err=0.
  - State SIGN; all accumulators 0.
- Latency, with the terminating 0x0A accepted on edge k:
  - Valid number: out_valid rises at edge k+FRAC_W+1.
  - Error: out_valid rises at edge k+1 and CONV is skipped.
- out_valid, out_value, out_zero and out_err are registered and stay stable while out_valid=1 and out_ready=0.
- in_ready returns high on the cycle after the out_valid/out_ready handshake edge. There is no bypass, so at most one number is in flight.
- An in_valid pulse while in_ready=0 is not consumed; the producer holds it.
- rst_n assertion at any point, including mid-number or in CONV/OUT, immediately clears state and outputs. The partial number is lost.
- Width rules:
  - int_acc: INT_W bits.
  - frac_acc and scale: enough bits for 2*10^MAX_FRAC_DIGITS (15 bits for the default).
  - The negation is done at INT_W+FRAC_W bits.

## Test plan
All values below use the default parameters.
- "0\n", "0.0\n", "-0.000\n": each gives out_value=0x0000, out_zero=1, out_err=0.
- "3.25\n" gives 0x0340. "-1.5\n" gives 0xFE80. "+2\n" gives 0x0200. All have out_zero=0.
- "0.1\n" gives 0x0019 (truncated 25.6). "127.99999\n" gives 0x7FFF, with the 5th fraction digit ignored.
- "128\n", "1a2\n", "1..2\n", "\n" and ".\n" each give out_err=1, out_value=0, out_zero=0. For each, out_valid comes one edge after the 0x0A.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles after "12\n": outputs stay stable and in_ready=0. Latency from 0x0A to out_valid is 9 edges.
  - Assert rst_n=0 after "12.": all outputs go to 0. Then "5\n" gives 0x0500.
